// File: rtl/ether_iload.sv
// ether_iload: stages aggregated Ethernet receive words for one frame, waits
// for the checksum verdict, then writes the frame's instruction words into
// the instruction bank. Bad, malformed, oversize or timed-out frames are
// discarded whole.
//
// Bank write handshake: ibank_wr_valid, ibank_wr_addr and ibank_wr_data are
// registered and hold steady while ibank_wr_valid is high and ibank_wr_ready
// is low; a write happens in any cycle where both are high, and the next
// word is presented the following cycle with no bubble.
module ether_iload #(
    parameter int         DEPTH       = 64,
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] MAGIC       = 8'hC5,
    parameter int         FCS_TIMEOUT = 1024
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic              axiiv,
    input  logic [31:0]       axiid,
    input  logic              fcs_done,
    input  logic              fcs_kill,
    output logic              ibank_wr_valid,
    input  logic              ibank_wr_ready,
    output logic [ADDR_W-1:0] ibank_wr_addr,
    output logic [31:0]       ibank_wr_data,
    output logic              load_done,
    output logic              busy,
    output logic [15:0]       good_count,
    output logic [15:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;                  // pointers must be able to hold DEPTH
    localparam int TW = $clog2(FCS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_FCS = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              fv_q, fv_d;
    logic              done_q, done_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              bad_q, bad_d;
    logic              ovf_q, ovf_d;
    logic              done_pend_q, done_pend_d;
    logic              kill_pend_q, kill_pend_d;
    logic              ign_q, ign_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              load_done_q, load_done_d;
    logic [15:0]       good_q, good_d;
    logic [15:0]       drop_q, drop_d;

    logic [31:0]       stage_mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    logic              fv_rise, fv_fall, done_rise;
    logic              take;
    logic              verdict_kill;
    logic              good_inc;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;
    logic [PW-1:0]     rd_next;

    assign fv_rise   = frame_valid & ~fv_q;
    assign fv_fall   = ~frame_valid & fv_q;
    assign done_rise = fcs_done & ~done_q;
    assign rd_next   = rd_ptr_q + PW'(1);

    // Next-state logic: frame start, word staging, verdict and bank drain.
    always_comb begin
        state_d      = state_q;
        fv_d         = frame_valid;
        done_d       = fcs_done;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        bad_d        = bad_q;
        ovf_d        = ovf_q;
        done_pend_d  = done_pend_q;
        kill_pend_d  = kill_pend_q;
        ign_d        = ign_q;
        timer_d      = timer_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_done_d  = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        take         = 1'b0;
        verdict_kill = 1'b0;
        good_inc     = 1'b0;
        drop_inc     = 2'd0;

        // A new frame in IDLE starts with a clean pointer and flags.
        if (state_q == IDLE && fv_rise) begin
            wr_ptr_d    = '0;
            bad_d       = 1'b0;
            ovf_d       = 1'b0;
            done_pend_d = 1'b0;
            kill_pend_d = 1'b0;
            ign_d       = 1'b0;
            state_d     = RECV;
        end

        // Words belong to the current frame in RECV and, while the aggregate
        // stage lags, in WAIT_FCS unless a newer frame has already begun.
        case (state_q)
            IDLE:     take = fv_rise & axiiv;
            RECV:     take = axiiv;
            WAIT_FCS: take = axiiv & ~ign_q & ~fv_rise;
            default:  take = 1'b0;
        endcase

        if (take) begin
            if (wr_ptr_d == PW'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = wr_ptr_d[AW-1:0];
                if (wr_ptr_d == '0) begin
                    bad_d  = bad_d | (axiid[31:24] != MAGIC);
                    base_d = axiid[ADDR_W-1:0];
                end
                wr_ptr_d = wr_ptr_d + PW'(1);
            end
        end

        case (state_q)
            RECV: begin
                // A verdict arriving before frame end is held until WAIT_FCS.
                if (done_rise) begin
                    done_pend_d = 1'b1;
                    kill_pend_d = fcs_kill;
                end
                if (fv_fall) begin
                    state_d = WAIT_FCS;
                    timer_d = '0;
                end
            end
            WAIT_FCS: begin
                timer_d = timer_q + TW'(1);
                if (fv_rise) begin
                    ign_d    = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                end
                if (done_pend_q || done_rise) begin
                    verdict_kill = done_pend_q ? kill_pend_q : fcs_kill;
                    done_pend_d  = 1'b0;
                    if (verdict_kill || bad_d || ovf_d || (wr_ptr_d < PW'(3))) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d      = wr_ptr_d - PW'(2);
                        rd_ptr_d   = PW'(1);
                        wr_valid_d = 1'b1;
                        wr_addr_d  = base_d;
                        wr_data_d  = stage_mem[AW'(1)];
                        state_d    = DRAIN;
                    end
                end else if (timer_q == TW'(FCS_TIMEOUT)) begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (fv_rise) begin
                    ign_d    = 1'b1;
                    drop_inc = drop_inc + 2'd1;
                end
                if (wr_valid_q && ibank_wr_ready) begin
                    if (rd_ptr_q == cnt_q) begin
                        wr_valid_d  = 1'b0;
                        load_done_d = 1'b1;
                        good_inc    = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        rd_ptr_d  = rd_next;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        wr_data_d = stage_mem[rd_next[AW-1:0]];
                    end
                end
            end
            default: ;
        endcase

        good_d   = (good_inc && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // State, flag, pointer, counter and output registers.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            fv_q        <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            bad_q       <= 1'b0;
            ovf_q       <= 1'b0;
            done_pend_q <= 1'b0;
            kill_pend_q <= 1'b0;
            ign_q       <= 1'b0;
            timer_q     <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            good_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            fv_q        <= fv_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            done_pend_q <= done_pend_d;
            kill_pend_q <= kill_pend_d;
            ign_q       <= ign_d;
            timer_q     <= timer_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
            good_q      <= good_d;
            drop_q      <= drop_d;
        end
    end

    // Staging buffer write port; contents need no reset.
    always_ff @(posedge clk_50mhz) begin
        if (mem_we) begin
            stage_mem[mem_waddr] <= axiid;
        end
    end

    assign ibank_wr_valid = wr_valid_q;
    assign ibank_wr_addr  = wr_addr_q;
    assign ibank_wr_data  = wr_data_q;
    assign load_done      = load_done_q;
    assign busy           = (state_q != IDLE);
    assign good_count     = good_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_ether_iload.sv
// Directed bench for ether_iload: one task per scenario, each checking its
// own results against hand-computed bank writes and counter values.
module tb_ether_iload;
  localparam int DEPTH = 64;

  logic        clk_50mhz = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic        axiiv = 1'b0;
  logic [31:0] axiid = '0;
  logic        fcs_done = 1'b0;
  logic        fcs_kill = 1'b0;
  logic        ibank_wr_ready = 1'b0;
  logic        ibank_wr_valid;
  logic [7:0]  ibank_wr_addr;
  logic [31:0] ibank_wr_data;
  logic        load_done;
  logic        busy;
  logic [15:0] good_count;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ld_cnt = 0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int          got_cyc_q[$];
  logic [31:0] frm_q[$];

  ether_iload #(.DEPTH(DEPTH), .ADDR_W(8), .MAGIC(8'hC5), .FCS_TIMEOUT(1024)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .frame_valid(frame_valid), .axiiv(axiiv),
    .axiid(axiid), .fcs_done(fcs_done), .fcs_kill(fcs_kill),
    .ibank_wr_valid(ibank_wr_valid), .ibank_wr_ready(ibank_wr_ready),
    .ibank_wr_addr(ibank_wr_addr), .ibank_wr_data(ibank_wr_data),
    .load_done(load_done), .busy(busy), .good_count(good_count), .drop_count(drop_count)
  );

  // clock / cycle count
  always #10 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  // bank write monitor, sampled mid-cycle
  always @(negedge clk_50mhz) begin
    if (ibank_wr_valid && ibank_wr_ready) begin
      got_q.push_back({ibank_wr_addr, ibank_wr_data});
      got_cyc_q.push_back(cyc);
    end
    if (load_done) ld_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; frame_valid = 1'b0; axiiv = 1'b0; axiid = '0;
    fcs_done = 1'b0; fcs_kill = 1'b0; ibank_wr_ready = 1'b0;
    repeat (3) @(posedge clk_50mhz);
    #1 rst = 1'b0;
    got_q.delete(); got_cyc_q.delete(); exp_q.delete(); ld_cnt = 0;
  endtask

  task automatic send_frame();
    @(posedge clk_50mhz); #1 frame_valid = 1'b1;
    foreach (frm_q[i]) begin
      @(posedge clk_50mhz); #1 axiiv = 1'b1; axiid = frm_q[i];
    end
    @(posedge clk_50mhz); #1 axiiv = 1'b0; frame_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic kill);
    @(posedge clk_50mhz); #1 fcs_done = 1'b1; fcs_kill = kill;
    @(posedge clk_50mhz); #1 fcs_done = 1'b0; fcs_kill = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk_50mhz); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b expected=0 after %0d cycles", name, busy, max_cyc);
    end
    repeat (2) @(posedge clk_50mhz);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({ibank_wr_valid, ibank_wr_addr, ibank_wr_data, load_done, busy} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%h d=%h ld=%b busy=%b expected all 0",
               ibank_wr_valid, ibank_wr_addr, ibank_wr_data, load_done, busy);
    end
    checks++;
    if ({good_count, drop_count} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters good=%0d drop=%0d expected 0 0", good_count, drop_count);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'hC500_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    exp_q = '{{8'h10, 32'h1111_1111}, {8'h11, 32'h2222_2222}, {8'h12, 32'h3333_3333}};
    send_frame();
    pulse_done(1'b0);
    wait_idle(50, "good");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL good_nwrites got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL good_write%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if ((got_cyc_q[1] - got_cyc_q[0] != 1) || (got_cyc_q[2] - got_cyc_q[1] != 1)) begin
        errors++;
        $display("FAIL good_consecutive cycles=%0d,%0d,%0d expected back-to-back",
                 got_cyc_q[0], got_cyc_q[1], got_cyc_q[2]);
      end
    end
    checks++;
    if (ld_cnt !== 1) begin
      errors++;
      $display("FAIL good_load_done pulses=%0d expected=1", ld_cnt);
    end
    checks++;
    if (good_count !== 16'd1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL good_counts good=%0d drop=%0d expected 1 0", good_count, drop_count);
    end
  endtask

  task automatic test_kill();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'hC500_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    send_frame();
    pulse_done(1'b1);
    wait_idle(50, "kill");
    checks++;
    if (got_q.size() !== 0 || ld_cnt !== 0) begin
      errors++;
      $display("FAIL kill_writes got=%0d ld=%0d expected 0 0", got_q.size(), ld_cnt);
    end
    checks++;
    if (drop_count !== 16'd1 || good_count !== 16'd0) begin
      errors++;
      $display("FAIL kill_counts good=%0d drop=%0d expected 0 1", good_count, drop_count);
    end
  endtask

  task automatic test_bad_magic();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'h7700_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    send_frame();
    pulse_done(1'b0);
    wait_idle(50, "magic");
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL magic_writes got=%0d expected=0", got_q.size());
    end
    checks++;
    if (drop_count !== 16'd1 || good_count !== 16'd0) begin
      errors++;
      $display("FAIL magic_counts good=%0d drop=%0d expected 0 1", good_count, drop_count);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'hC500_00FE, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'h0BAD_F00D};
    exp_q = '{{8'hFE, 32'hA000_0001}, {8'hFF, 32'hA000_0002}, {8'h00, 32'hA000_0003}};
    send_frame();
    pulse_done(1'b0);
    wait_idle(50, "wrap");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL wrap_nwrites got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_write%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q.delete();
    frm_q.push_back(32'hC500_0000);
    for (int i = 1; i < DEPTH + 4; i++) frm_q.push_back(32'h5000_0000 + 32'(i));
    send_frame();
    pulse_done(1'b0);
    wait_idle(50, "ovf");
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL ovf_writes got=%0d expected=0", got_q.size());
    end
    checks++;
    if (drop_count !== 16'd1 || good_count !== 16'd0) begin
      errors++;
      $display("FAIL ovf_counts good=%0d drop=%0d expected 0 1", good_count, drop_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ibank_wr_ready = 1'b0;
    frm_q = '{32'hC500_0020, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
              32'hB000_0004, 32'hCAFE_CAFE};
    exp_q = '{{8'h20, 32'hB000_0001}, {8'h21, 32'hB000_0002},
              {8'h22, 32'hB000_0003}, {8'h23, 32'hB000_0004}};
    send_frame();
    pulse_done(1'b0);
    checks++;
    if ({ibank_wr_valid, ibank_wr_addr, ibank_wr_data} !== {1'b1, 8'h20, 32'hB000_0001}) begin
      errors++;
      $display("FAIL bp_first got v=%b a=%h d=%h expected 1 20 b0000001",
               ibank_wr_valid, ibank_wr_addr, ibank_wr_data);
    end
    ibank_wr_ready = 1'b1;
    @(posedge clk_50mhz); #1;
    ibank_wr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_50mhz); #1;
      checks++;
      if ({ibank_wr_valid, ibank_wr_addr, ibank_wr_data} !== {1'b1, 8'h21, 32'hB000_0002}) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b a=%h d=%h expected 1 21 b0000002",
                 k, ibank_wr_valid, ibank_wr_addr, ibank_wr_data);
      end
    end
    ibank_wr_ready = 1'b1;
    wait_idle(50, "bp");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_nwrites got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_write%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_early_done();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'hC500_0030, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hFEED_0000};
    exp_q = '{{8'h30, 32'hD000_0001}, {8'h31, 32'hD000_0002}, {8'h32, 32'hD000_0003}};
    @(posedge clk_50mhz); #1 frame_valid = 1'b1;
    foreach (frm_q[i]) begin
      @(posedge clk_50mhz); #1 axiiv = 1'b1; axiid = frm_q[i];
      if (i == 2) fcs_done = 1'b1;
    end
    @(posedge clk_50mhz); #1 axiiv = 1'b0; frame_valid = 1'b0;
    @(posedge clk_50mhz); #1 fcs_done = 1'b0;
    wait_idle(50, "early");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL early_nwrites got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL early_write%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (good_count !== 16'd1) begin
      errors++;
      $display("FAIL early_good got=%0d expected=1", good_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ibank_wr_ready = 1'b1;
    frm_q = '{32'hC500_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    send_frame();
    repeat (1000) @(posedge clk_50mhz);
    #1;
    checks++;
    if (busy !== 1'b1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL timeout_early busy=%b drop=%0d expected 1 0", busy, drop_count);
    end
    wait_idle(60, "timeout");
    checks++;
    if (drop_count !== 16'd1 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_drop drop=%0d writes=%0d expected 1 0", drop_count, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ibank_wr_ready = 1'b0;
    frm_q = '{32'hC500_0040, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
              32'hC000_0004, 32'hC000_0005, 32'h1234_5678};
    exp_q = '{{8'h40, 32'hC000_0001}, {8'h41, 32'hC000_0002}, {8'h42, 32'hC000_0003},
              {8'h43, 32'hC000_0004}, {8'h44, 32'hC000_0005}};
    send_frame();
    pulse_done(1'b0);
    frame_valid = 1'b1;
    @(posedge clk_50mhz); #1;
    axiiv = 1'b1; axiid = 32'hC500_0099;
    @(posedge clk_50mhz); #1;
    ibank_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axiid = 32'hEE00_0000 + 32'(i);
      @(posedge clk_50mhz); #1;
    end
    axiiv = 1'b0; frame_valid = 1'b0;
    pulse_done(1'b0);
    wait_idle(50, "b2b");
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_nwrites got=%0d expected=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_write%0d got=%h expected=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (good_count !== 16'd1 || drop_count !== 16'd1 || ld_cnt !== 1) begin
      errors++;
      $display("FAIL b2b_counts good=%0d drop=%0d ld=%0d expected 1 1 1",
               good_count, drop_count, ld_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    frm_q = '{32'h7700_0000, 32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF};
    send_frame();
    pulse_done(1'b0);
    frm_q = '{32'hC500_0010, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
    send_frame();
    pulse_done(1'b0);
    checks++;
    if (ibank_wr_valid !== 1'b1 || drop_count !== 16'd1) begin
      errors++;
      $display("FAIL rstdrain_pre v=%b drop=%0d expected 1 1", ibank_wr_valid, drop_count);
    end
    rst = 1'b1;
    @(posedge clk_50mhz); #1;
    checks++;
    if (ibank_wr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstdrain_valid v=%b busy=%b expected 0 0", ibank_wr_valid, busy);
    end
    checks++;
    if (good_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL rstdrain_counts good=%0d drop=%0d expected 0 0", good_count, drop_count);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk_50mhz);
    #1;
    checks++;
    if (got_q.size() !== 0 || good_count !== 16'd0) begin
      errors++;
      $display("FAIL rstdrain_lost writes=%0d good=%0d expected 0 0", got_q.size(), good_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_frame();
    test_kill();
    test_bad_magic();
    test_addr_wrap();
    test_overflow();
    test_backpressure();
    test_early_done();
    test_timeout();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ether_iload.md
Name: ether_iload

Overview:
- Sits downstream of the aggregate stage in the clk_50mhz Ethernet receive chain.
- Stages each frame's 32-bit words in a local buffer and waits for the cksum verdict.
- Good-FCS load frames are written, word by word, into the processor's instruction bank write port. Bad, malformed, oversize or timed-out frames are discarded whole.
- Implements the "route agg_axiod to instruction bank" path.

Parameters:
- DEPTH, 64: staging buffer depth in 32-bit words; power of 2.
- ADDR_W, 8: instruction bank address width.
- MAGIC, 8'hC5: required value of header[31:24].
- FCS_TIMEOUT, 1024: cycles to wait for the FCS verdict after frame end.

Ports:
- clk_50mhz in 1: clock.
- rst in 1: synchronous, active-high reset.
- frame_valid in 1: high for the duration of a received frame (ether axiov).
- axiiv in 1: aggregated word valid.
- axiid in 32: aggregated word.
- fcs_done in 1: cksum done, level; the block edge-detects it.
- fcs_kill in 1: cksum kill; sampled on the fcs_done rising edge.
- ibank_wr_valid out 1: bank write request.
- ibank_wr_ready in 1: bank accepts the write.
- ibank_wr_addr out ADDR_W: bank write address.
- ibank_wr_data out 32: instruction word.
- load_done out 1: one-cycle pulse after the last bank write of a frame.
- busy out 1: high in any state other than IDLE.
- good_count out 16: count of frames committed.
- drop_count out 16: count of frames discarded.

Behaviour:
- Reset: state IDLE, all pointers, flags and counters cleared; every output is 0.
- Frame layout: word0 is the header; words 1..N-2 are instructions; word N-1 is the FCS and is never written.
  - header[31:24] must equal MAGIC.
  - header[ADDR_W-1:0] is the base address.
  - Instruction k is written to (base+k-1) mod 2^ADDR_W; the address wraps silently.
- States:
  - IDLE: on a frame_valid rising edge, clear the write pointer, clear the bad/ovf flags, go to RECV.
  - RECV: each axiiv word is stored at wr_ptr, then wr_ptr+1.
    - Word0 with a wrong magic sets bad.
    - A word arriving with wr_ptr==DEPTH is not stored and sets ovf.
    - On frame_valid falling, go to WAIT_FCS and clear the timer.
  - WAIT_FCS: words are still accepted (aggregate lag), under the same rules as RECV.
    - On the fcs_done rising edge: if fcs_kill, bad, ovf, or word count < 3, then drop_count+1 and go to IDLE. Otherwise latch cnt = words-2, set rd_ptr=1, go to DRAIN.
    - If the timer reaches FCS_TIMEOUT, then drop_count+1 and go to IDLE.
  - DRAIN: ibank_wr_valid=1 with addr=base+rd_ptr-1 and data=buf[rd_ptr].
    - Outputs hold stable until ibank_wr_valid && ibank_wr_ready; then rd_ptr+1.
    - After the cnt-th accepted write: ibank_wr_valid=0 the next cycle, load_done=1 for one cycle, good_count+1, go to IDLE.
- FCS edge timing: an fcs_done rising edge seen in RECV is latched and applied on entry to WAIT_FCS. The same-cycle frame end and done is handled identically.
- Frame starts while in WAIT_FCS or DRAIN: the whole frame is ignored (no words stored) and drop_count+1 at its start. The current frame is unaffected.
- Counters saturate at 16'hFFFF.
- Buffer: 1 write and 1 read per cycle; synchronous-read RAM is permitted. If one is used, DRAIN prefetches so that valid data is presented with valid, with no bubble between accepted writes when ready stays high.
- Reset mid-DRAIN: writes stop immediately, ibank_wr_valid=0 on the next cycle, and the frame is lost without being counted.

Test Plan:
- Good frame, header 0xC5000010, instructions 0x11111111, 0x22222222, 0x33333333, then FCS, fcs_done with kill=0, ready tied high:
  - writes (0x10,0x11111111), (0x11,0x22222222), (0x12,0x33333333) on consecutive cycles;
  - load_done pulses once; good_count=1.
- Same frame with fcs_kill=1 at done -> zero bank writes; drop_count=1.
- Header 0x77000000 with good FCS -> no writes; drop_count=1.
- Base 0xFE with 3 instructions -> addresses 0xFE, 0xFF, 0x00.
- DEPTH+4 words -> no writes; drop_count=1.
- ready toggled 1,0,0,1 -> addr and data held while ready low; no write duplicated or skipped.
- Frame end with no fcs_done for 1024 cycles -> drop_count=1; returns to IDLE; busy=0.
- Second frame begins during DRAIN -> first frame completes intact; drop_count+1.
- rst asserted mid-DRAIN -> ibank_wr_valid=0 next cycle; all counters 0.
